// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instruction words (plus the immediate word for mvi)
// from a synchronous ROM and feeds them to the 16-bit core. It drives Run and
// waits for Done, and repeats until a HALT opcode or an execution timeout.
//
// Ports:
//   Clock, Resetn  - clock; synchronous active-low reset
//   Start          - start/restart from address 0 (IDLE, HALTED, FAULT only)
//   Addr           - ROM read address (equals PC)
//   MemData        - ROM read data, valid the cycle after Addr
//   DIN            - word presented to the core
//   Run            - core run enable (ISSUE and EXEC)
//   Done           - core instruction-complete flag (sampled in EXEC only)
//   Busy           - sequencing an instruction
//   Halted, Fault  - terminal status flags
//   InstrCount     - instructions completed since the last Start
module prog_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault,
    output logic [15:0]       InstrCount
);

    localparam int unsigned STEP_W  = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  OP_MVI  = 4'b0001;
    localparam logic [3:0]  OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_FETCH_IMM,
        S_LATCH_IMM,
        S_ISSUE,
        S_EXEC,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [15:0]         ir_q;
    logic [15:0]         imm_q;
    logic [15:0]         din_q;
    logic [15:0]         count_q;
    logic [STEP_W-1:0]   step;

    // Sequencer state machine and datapath registers
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            count_q <= '0;
            step    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (Start) begin
                        pc      <= '0;
                        count_q <= '0;
                        step    <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    ir_q <= MemData;
                    pc   <= pc + ADDR_W'(1);
                    if (MemData[15:12] == OP_HALT) begin
                        state <= S_HALTED;
                    end else if (MemData[15:12] == OP_MVI) begin
                        state <= S_FETCH_IMM;
                    end else begin
                        // DIN must already show the instruction during ISSUE
                        din_q <= MemData;
                        state <= S_ISSUE;
                    end
                end
                S_FETCH_IMM: begin
                    state <= S_LATCH_IMM;
                end
                S_LATCH_IMM: begin
                    imm_q <= MemData;
                    pc    <= pc + ADDR_W'(1);
                    din_q <= ir_q;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Core loads IR in step 0; from EXEC on it sees the operand word
                    step  <= STEP_W'(1);
                    din_q <= (ir_q[15:12] == OP_MVI) ? imm_q : ir_q;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // Done on the last allowed cycle still counts as completion
                    if (Done) begin
                        count_q <= count_q + 16'(1);
                        state   <= S_FETCH;
                    end else if (step == STEP_W'(TIMEOUT)) begin
                        state <= S_FAULT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    assign Addr       = pc;
    assign DIN        = din_q;
    assign InstrCount = count_q;
    assign Run        = (state == S_ISSUE) || (state == S_EXEC);
    assign Busy       = (state == S_FETCH) || (state == S_LATCH) ||
                        (state == S_FETCH_IMM) || (state == S_LATCH_IMM) ||
                        (state == S_ISSUE) || (state == S_EXEC);
    assign Halted     = (state == S_HALTED);
    assign Fault      = (state == S_FAULT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer with a 4-word synchronous ROM
// (ADDR_W=2) and a small core stand-in that can answer Done in the first
// EXEC cycle or be forced by the bench.
module tb_prog_sequencer;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       mem_data;
    logic [15:0]       din;
    logic              run;
    logic              done;
    logic              busy;
    logic              halted;
    logic              fault;
    logic [15:0]       instr_count;

    logic [15:0]       rom [0:3];
    logic              auto_done = 1'b0;
    logic              done_force = 1'b0;
    logic              run_d = 1'b0;

    int checks = 0;
    int failures = 0;
    int runs;

    prog_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock      (clk),
        .Resetn     (resetn),
        .Start      (start),
        .Addr       (addr),
        .MemData    (mem_data),
        .DIN        (din),
        .Run        (run),
        .Done       (done),
        .Busy       (busy),
        .Halted     (halted),
        .Fault      (fault),
        .InstrCount (instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM and Run history for the core stand-in
    always @(posedge clk) begin
        mem_data <= rom[addr];
        run_d    <= run;
    end

    // Core stand-in: Done in the first EXEC cycle (second Run cycle)
    assign done = (auto_done && run && run_d) || done_force;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for Halted or Fault, counting Run-high cycles on the way
    task automatic wait_end(input string tag, output int run_cnt);
        logic seen;
        seen    = 1'b0;
        run_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted || fault) begin
                seen = 1'b1;
                break;
            end
            if (run) run_cnt++;
        end
        chk({tag, "_reached_end"}, 16'(seen), 16'd1);
    endtask

    initial begin
        rom[0] = 16'h0000;
        rom[1] = 16'hF000;
        rom[2] = 16'h0000;
        rom[3] = 16'h0000;
        auto_done = 1'b1;

        // Reset with Start held high: reset wins
        resetn = 1'b0;
        start  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",   16'(addr), 16'd0);
        chk("rst_din",    din, 16'h0000);
        chk("rst_run",    16'(run), 16'd0);
        chk("rst_busy",   16'(busy), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_fault",  16'(fault), 16'd0);
        chk("rst_count",  instr_count, 16'd0);
        resetn = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        chk("idle_busy", 16'(busy), 16'd0);

        // Single mv R0,R0 then HALT
        start = 1'b1;
        @(negedge clk);                       // FETCH
        start = 1'b0;
        chk("mv_fetch_busy", 16'(busy), 16'd1);
        chk("mv_fetch_run",  16'(run), 16'd0);
        chk("mv_fetch_addr", 16'(addr), 16'd0);
        @(negedge clk);                       // LATCH
        chk("mv_latch_run", 16'(run), 16'd0);
        @(negedge clk);                       // ISSUE
        chk("mv_issue_run", 16'(run), 16'd1);
        chk("mv_issue_din", din, 16'h0000);
        @(negedge clk);                       // EXEC
        chk("mv_exec_run", 16'(run), 16'd1);
        chk("mv_exec_din", din, 16'h0000);
        @(negedge clk);                       // FETCH of HALT
        chk("mv_next_run",   16'(run), 16'd0);
        chk("mv_next_count", instr_count, 16'd1);
        chk("mv_next_addr",  16'(addr), 16'd1);
        @(negedge clk);                       // LATCH of HALT
        @(negedge clk);                       // HALTED
        chk("mv_halted", 16'(halted), 16'd1);
        chk("mv_busy",   16'(busy), 16'd0);
        chk("mv_count",  instr_count, 16'd1);
        chk("mv_addr",   16'(addr), 16'd2);

        // mvi R1, #00A5 then HALT; Start held into FETCH is ignored
        rom[0] = 16'h1200;
        rom[1] = 16'h00A5;
        rom[2] = 16'hF000;
        start = 1'b1;
        @(negedge clk);                       // FETCH
        chk("mvi_fetch_addr",   16'(addr), 16'd0);
        chk("mvi_fetch_halted", 16'(halted), 16'd0);
        @(negedge clk);                       // LATCH
        start = 1'b0;
        chk("mvi_latch_busy", 16'(busy), 16'd1);
        @(negedge clk);                       // FETCH_IMM
        chk("mvi_fimm_run",  16'(run), 16'd0);
        chk("mvi_fimm_addr", 16'(addr), 16'd1);
        @(negedge clk);                       // LATCH_IMM
        chk("mvi_limm_run", 16'(run), 16'd0);
        @(negedge clk);                       // ISSUE
        chk("mvi_issue_run", 16'(run), 16'd1);
        chk("mvi_issue_din", din, 16'h1200);
        @(negedge clk);                       // EXEC
        chk("mvi_exec_run", 16'(run), 16'd1);
        chk("mvi_exec_din", din, 16'h00A5);
        wait_end("mvi", runs);
        chk("mvi_halted", 16'(halted), 16'd1);
        chk("mvi_count",  instr_count, 16'd1);
        chk("mvi_pc",     16'(addr), 16'd3);

        // Timeout: Done never arrives
        rom[0] = 16'h2000;
        rom[1] = 16'hF000;
        auto_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("tmo", runs);
        chk("tmo_run_cycles", 16'(runs), 16'd9);
        chk("tmo_fault",  16'(fault), 16'd1);
        chk("tmo_run",    16'(run), 16'd0);
        chk("tmo_busy",   16'(busy), 16'd0);
        chk("tmo_count",  instr_count, 16'd0);
        chk("tmo_din",    din, 16'h2000);

        // Restart from FAULT; Done outside EXEC ignored; Done on the last EXEC cycle completes
        start = 1'b1;
        @(negedge clk);                       // FETCH
        chk("rs_fault", 16'(fault), 16'd0);
        chk("rs_addr",  16'(addr), 16'd0);
        chk("rs_busy",  16'(busy), 16'd1);
        start = 1'b0;
        done_force = 1'b1;
        @(negedge clk);                       // LATCH
        @(negedge clk);                       // ISSUE
        done_force = 1'b0;
        chk("rs_issue_run",   16'(run), 16'd1);
        chk("rs_issue_din",   din, 16'h2000);
        chk("rs_issue_count", instr_count, 16'd0);
        repeat (7) @(negedge clk);            // EXEC 1..7
        @(negedge clk);                       // EXEC 8
        chk("edge_exec8_run",   16'(run), 16'd1);
        chk("edge_exec8_fault", 16'(fault), 16'd0);
        done_force = 1'b1;
        @(negedge clk);                       // FETCH
        done_force = 1'b0;
        chk("edge_fault", 16'(fault), 16'd0);
        chk("edge_count", instr_count, 16'd1);
        chk("edge_run",   16'(run), 16'd0);
        chk("edge_addr",  16'(addr), 16'd1);
        wait_end("edge", runs);
        chk("edge_halted", 16'(halted), 16'd1);
        chk("edge_pc",     16'(addr), 16'd2);

        // Wrap: mvi at the last address takes its immediate from address 0
        rom[0] = 16'h0042;
        rom[1] = 16'h0000;
        rom[2] = 16'h0000;
        rom[3] = 16'h1000;
        auto_done = 1'b1;
        start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        repeat (11) @(negedge clk);           // cycle 12
        @(negedge clk);                       // cycle 13: FETCH @3
        chk("wrap_fetch_addr", 16'(addr), 16'd3);
        @(negedge clk);                       // LATCH
        @(negedge clk);                       // FETCH_IMM @0
        chk("wrap_fimm_addr", 16'(addr), 16'd0);
        @(negedge clk);                       // LATCH_IMM
        @(negedge clk);                       // ISSUE
        chk("wrap_issue_din",  din, 16'h1000);
        chk("wrap_issue_addr", 16'(addr), 16'd1);
        @(negedge clk);                       // EXEC
        chk("wrap_exec_din",   din, 16'h0042);
        chk("wrap_exec_count", instr_count, 16'd3);
        @(negedge clk);                       // FETCH @1
        chk("wrap_count", instr_count, 16'd4);
        chk("wrap_addr",  16'(addr), 16'd1);
        auto_done = 1'b0;

        // Reset in the middle of EXEC
        @(negedge clk);                       // LATCH
        @(negedge clk);                       // ISSUE
        @(negedge clk);                       // EXEC 1
        @(negedge clk);                       // EXEC 2
        chk("mid_exec_run", 16'(run), 16'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_run",   16'(run), 16'd0);
        chk("mid_rst_addr",  16'(addr), 16'd0);
        chk("mid_rst_busy",  16'(busy), 16'd0);
        chk("mid_rst_count", instr_count, 16'd0);
        chk("mid_rst_din",   din, 16'h0000);
        resetn = 1'b1;
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        chk("late_done_count", instr_count, 16'd0);
        chk("late_done_run",   16'(run), 16'd0);
        chk("late_done_busy",  16'(busy), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer that feeds the 16-bit processor core from a synchronous instruction memory. It fetches instruction words (and the immediate word for `mvi`) and presents them on the core's `DIN`. It drives the core's `Run` and waits for `Done`, repeating until a halt opcode or an execution timeout. It sits between the instruction ROM and the `processador` instance and owns the program counter.

## Interface
- `ADDR_W`, default 5: instruction memory address width; PC wraps modulo 2^ADDR_W.
- `TIMEOUT`, default 8: maximum EXEC cycles allowed before `Done` must arrive.
- `Clock` in 1: single clock, all state changes on the rising edge.
- `Resetn` in 1: reset, synchronous, active-low.
- `Start` in 1: begin or restart the program from address 0; sampled in IDLE, HALTED and FAULT.
- `Addr` out ADDR_W: instruction memory read address; equals PC.
- `MemData` in 16: memory read data, valid the cycle after `Addr` is presented.
- `DIN` out 16: word presented to the core.
- `Run` out 1: core run enable.
- `Done` in 1: core instruction-complete flag.
- `Busy` out 1: high in FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE and EXEC.
- `Halted` out 1: high in HALTED.
- `Fault` out 1: high in FAULT.
- `InstrCount` out 16: number of instructions completed since the last Start; wraps.

## Operation
- Word format:
  - opcode = word[15:12].
  - X = word[11:9], Y = word[8:6].
  - Opcode 4'b0001 (`mvi`) is followed by one immediate word.
  - Opcode 4'b1111 is HALT and is never issued to the core.
- Internal registers: PC, IR_q (instruction word), IMM_q (immediate word), step counter.
- States and transitions:
  - IDLE: if `Start`, clear PC, `InstrCount` and the step counter, then go to FETCH.
  - FETCH: `Addr`=PC → LATCH.
  - LATCH: IR_q←`MemData`; PC←PC+1.
    - Opcode HALT → HALTED.
    - Opcode `mvi` → FETCH_IMM.
    - Otherwise → ISSUE.
  - FETCH_IMM: `Addr`=PC → LATCH_IMM.
  - LATCH_IMM: IMM_q←`MemData`; PC←PC+1 → ISSUE.
  - ISSUE: `Run`=1; `DIN`=IR_q (core step 0 loads IR); step←1 → EXEC.
  - EXEC: `Run`=1.
    - `DIN`=IMM_q if IR_q is `mvi`, else IR_q.
    - `Done`=1: `InstrCount`+1 → FETCH.
    - Else, if step == TIMEOUT → FAULT.
    - Else step+1.
  - HALTED / FAULT: `Run`=0; hold PC, IR_q and `InstrCount`. `Start` behaves as in IDLE (restart from address 0 → FETCH).
- `Done` is sampled only in EXEC. `Done` in any other state is ignored.
- `Start` is ignored while `Busy` is high.
- `Run` is low in every state except ISSUE and EXEC. FETCH therefore always gives at least one `Run`=0 cycle between instructions, which clears the core's step counter.
- PC increments modulo 2^ADDR_W, with no flag on wrap. An `mvi` at the last address takes its immediate from address 0.
- `DIN` holds its last value outside ISSUE and EXEC.

## Timing
- Reset values: state IDLE, PC=0, `Addr`=0, `DIN`=0, `Run`=0, `Busy`=0, `Halted`=0, `Fault`=0, `InstrCount`=0.
- `Resetn` low at any rising edge, including mid-EXEC, forces the reset values at that edge. `Run` is therefore low in the following cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from `Done` or `MemData` to any output.
- Overhead per instruction before `Run` rises: 2 cycles for non-`mvi`, 4 cycles for `mvi`.
- Total cycles per instruction = overhead + 1 (ISSUE) + k, where k = number of EXEC cycles up to and including the `Done` cycle.
- `Start` at edge n puts the core in step 0 with `Run`=1 at cycle n+3 for a non-`mvi` first word.
- The cycle after HALT's LATCH has `Halted`=1 and `Busy`=0.
- Timeout: FAULT is entered on the edge after the TIMEOUT-th EXEC cycle without `Done`.
- Simultaneous events: `Done`=1 on the TIMEOUT-th EXEC cycle counts as completion, not a fault. `Start` and `Resetn`=0 together resolves to reset.

## Test plan
- **Reset:** hold `Resetn`=0 for 2 cycles with `Start`=1 → all outputs at reset values, state IDLE.
- **Single `mv`:** ROM[0]=16'h0000 (`mv` R0,R0), ROM[1]=16'hF000; core raises `Done` in its first EXEC cycle.
  - Expected: `Run` high for exactly 2 cycles with `DIN`=16'h0000.
  - Then `Halted`=1, `InstrCount`=1, `Addr`=2.
- **`mvi`:** ROM[0]=16'h1200 (`mvi` R1), ROM[1]=16'h00A5, ROM[2]=16'hF000.
  - Expected: ISSUE has `DIN`=16'h1200; EXEC has `DIN`=16'h00A5.
  - Then `InstrCount`=1 and PC=3 at halt.
- **Timeout:** ROM[0]=16'h2000 with `Done` never asserted → `Fault`=1 after 8 EXEC cycles, `Run`=0, `InstrCount`=0.
  - Then `Start` → PC=0, `Fault`=0, refetch of address 0.
- **Wrap:** ADDR_W=2, ROM[3]=16'h1000, ROM[0]=16'h0042 → the immediate issued in EXEC is 16'h0042 and PC wraps to 1.
- **Reset mid-EXEC:** deassert reset, run, then pull `Resetn`=0 during EXEC → `Run`=0 the next cycle, PC=0, and `Done` arriving afterwards has no effect.
